// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 12-bit PRBS r(n)=r(n-1)^r(n-4)^r(n-6)^r(n-12).
// Optional bit counter for BER measurement is enabled with `define PRBS_CHK_BITCNT_EN.
module prbs_checker #(
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_WIN = 64,
    parameter int unsigned LOSS_ERR = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_in,
    input  logic             load_in,
    input  logic             clr_cnt,
    output logic             lock,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
`ifdef PRBS_CHK_BITCNT_EN
    output logic             sync_loss,
    output logic [CNT_W+7:0] bit_cnt
`else
    output logic             sync_loss
`endif
);

    localparam int unsigned FILL_LEN = 12;
    localparam int unsigned FILL_W   = 4;
    localparam int unsigned GOOD_W   = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W    = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int unsigned WERR_W   = $clog2(LOSS_ERR + 1);

    typedef enum logic {
        S_SEARCH,
        S_LOCKED
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [11:0]         r_hist, w_hist_nxt;
    logic [FILL_W-1:0]   r_fill, w_fill_nxt;
    logic [GOOD_W-1:0]   r_good, w_good_nxt;
    logic [WIN_W-1:0]    r_win, w_win_nxt;
    logic [WERR_W-1:0]   r_werr, w_werr_nxt;
    logic                r_lock, w_lock_nxt;
    logic                r_err, w_err_nxt;
    logic                r_sl, w_sl_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                w_valid;
    logic                w_pred;
    logic                w_mis;
    logic                w_cnt_inc;

    assign w_valid = en & load_in;
    assign w_pred  = r_hist[0] ^ r_hist[3] ^ r_hist[5] ^ r_hist[11];
    assign w_mis   = data_in ^ w_pred;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_SEARCH;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_good_nxt  = r_good;
        w_win_nxt   = r_win;
        w_werr_nxt  = r_werr;
        w_lock_nxt  = r_lock;
        w_err_nxt   = 1'b0;
        w_sl_nxt    = 1'b0;
        w_cnt_inc   = 1'b0;
        if (w_valid) begin
            case (r_state)
                S_SEARCH: begin
                    w_hist_nxt = {r_hist[10:0], data_in};
                    if (r_fill != FILL_W'(FILL_LEN)) begin
                        w_fill_nxt = r_fill + FILL_W'(1);
                    end else if (!w_mis && r_hist != '0) begin
                        if (r_good == GOOD_W'(LOCK_CNT - 1)) begin
                            w_state_nxt = S_LOCKED;
                            w_lock_nxt  = 1'b1;
                            w_good_nxt  = '0;
                            w_win_nxt   = '0;
                            w_werr_nxt  = '0;
                        end else begin
                            w_good_nxt = r_good + GOOD_W'(1);
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    // Flywheel: feed back the prediction so one channel error counts once.
                    w_hist_nxt = {r_hist[10:0], w_pred};
                    w_err_nxt  = w_mis;
                    w_cnt_inc  = w_mis;
                    if (w_mis && r_werr == WERR_W'(LOSS_ERR - 1)) begin
                        w_state_nxt = S_SEARCH;
                        w_lock_nxt  = 1'b0;
                        w_sl_nxt    = 1'b1;
                        w_fill_nxt  = '0;
                        w_good_nxt  = '0;
                        w_win_nxt   = '0;
                        w_werr_nxt  = '0;
                    end else if (r_win == WIN_W'(LOSS_WIN - 1)) begin
                        w_win_nxt  = '0;
                        w_werr_nxt = '0;
                    end else begin
                        w_win_nxt  = r_win + WIN_W'(1);
                        w_werr_nxt = r_werr + WERR_W'(w_mis);
                    end
                end
                default: w_state_nxt = S_SEARCH;
            endcase
        end

        w_cnt_nxt = r_cnt;
        if (clr_cnt)
            w_cnt_nxt = w_cnt_inc ? CNT_W'(1) : '0;
        else if (w_cnt_inc && r_cnt != '1)
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_good <= '0;
            r_win  <= '0;
            r_werr <= '0;
            r_lock <= 1'b0;
            r_err  <= 1'b0;
            r_sl   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_good <= w_good_nxt;
            r_win  <= w_win_nxt;
            r_werr <= w_werr_nxt;
            r_lock <= w_lock_nxt;
            r_err  <= w_err_nxt;
            r_sl   <= w_sl_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign lock      = r_lock;
    assign err       = r_err;
    assign sync_loss = r_sl;
    assign err_cnt   = r_cnt;

`ifdef PRBS_CHK_BITCNT_EN
    localparam int unsigned BC_W = CNT_W + 8;

    logic [BC_W-1:0] r_bc;
    logic            w_bc_inc;

    assign w_bc_inc = w_valid & r_lock;

    always_ff @(posedge clk) begin
        if (rst)
            r_bc <= '0;
        else if (clr_cnt)
            r_bc <= w_bc_inc ? BC_W'(1) : '0;
        else if (w_bc_inc && r_bc != '1)
            r_bc <= r_bc + BC_W'(1);
    end

    assign bit_cnt = r_bc;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: directed PRBS stimulus with planted errors at fixed bit indices.
// Build with +define+PRBS_CHK_BITCNT_EN to also check bit_cnt.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst, en, data_in, load_in, clr_cnt;
    logic        lock, err, sync_loss;
    logic [15:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [23:0] bit_cnt;
`endif

    always #5 clk = ~clk;

    prbs_checker #(
        .LOCK_CNT(16),
        .LOSS_WIN(64),
        .LOSS_ERR(4),
        .CNT_W   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .load_in  (load_in),
        .clr_cnt  (clr_cnt),
        .lock     (lock),
        .err      (err),
        .err_cnt  (err_cnt),
`ifdef PRBS_CHK_BITCNT_EN
        .sync_loss(sync_loss),
        .bit_cnt  (bit_cnt)
`else
        .sync_loss(sync_loss)
`endif
    );

    typedef struct {
        logic        lk;
        logic        er;
        logic        sl;
        logic [15:0] cnt;
        logic [23:0] bc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic src [0:2999];
    int   sp;
    int   cnt;
    int   e_bc;
    logic p_lock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s t=%0t got=%0d required=%0d", nm, $time, act, req);
    endtask

    // Drive one cycle and queue the response expected right after its rising edge.
    task automatic step(input logic r, input logic e, input logic l, input logic d, input logic c,
                        input logic xl, input logic xe, input logic xs, input int xc);
        exp_t x;
        logic inc;
        @(negedge clk);
        rst = r; en = e; load_in = l; data_in = d; clr_cnt = c;
        inc = e & l & p_lock;
        if (r)        e_bc = 0;
        else if (c)   e_bc = inc ? 1 : 0;
        else if (inc) e_bc = e_bc + 1;
        p_lock = r ? 1'b0 : xl;
        x.lk = xl; x.er = xe; x.sl = xs; x.cnt = 16'(xc); x.bc = 24'(e_bc);
        q.push_back(x);
    endtask

    task automatic idle_pair(input logic xl, input int xc);
        step(0, 0, 1, 1'($urandom_range(0, 1)), 0, xl, 0, 0, xc);
        step(0, 1, 0, 1'($urandom_range(0, 1)), 0, xl, 0, 0, xc);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("lock",      32'(lock),      32'(x.lk));
                chk("err",       32'(err),       32'(x.er));
                chk("sync_loss", 32'(sync_loss), 32'(x.sl));
                chk("err_cnt",   32'(err_cnt),   32'(x.cnt));
`ifdef PRBS_CHK_BITCNT_EN
                chk("bit_cnt",   32'(bit_cnt),   32'(x.bc));
`endif
            end
        end
    end

    initial begin : stim
        logic b, e;
        rst = 1'b1; en = 1'b0; load_in = 1'b0; data_in = 1'b0; clr_cnt = 1'b0;
        p_lock = 1'b0; e_bc = 0; cnt = 0; sp = 0;
        for (int n = 0; n < 3000; n++)
            src[n] = (n < 12) ? 1'b1 : (src[n-1] ^ src[n-4] ^ src[n-6] ^ src[n-12]);

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 0, 0, 0);

        // Clean source: lock on the 28th valid bit (index 27), no errors.
        for (int g = 0; g < 1000; g++) begin
            step(0, 1, 1, src[sp], 0, g >= 27, 0, 0, 0);
            sp++;
        end

        // Single inverted bit, with idle cycles interleaved.
        for (int g = 1000; g < 1300; g++) begin
            e = (g == 1200);
            if (e) cnt++;
            step(0, 1, 1, src[sp] ^ e, 0, 1, e, 0, cnt);
            sp++;
            if (g % 5 == 4) idle_pair(1, cnt);
        end

        // Four errors inside window [1308..1371]: loss on 1316, relock on 1344.
        for (int g = 1300; g < 1500; g++) begin
            e = (g == 1310) || (g == 1312) || (g == 1314) || (g == 1316);
            if (e) cnt++;
            step(0, 1, 1, src[sp] ^ e, 0, (g < 1316) || (g >= 1344), e, g == 1316, cnt);
            sp++;
        end

        // Three errors in window [1473..1536], three in [1537..1600]: no loss.
        for (int g = 1500; g < 1700; g++) begin
            e = (g == 1510) || (g == 1512) || (g == 1514) ||
                (g == 1540) || (g == 1542) || (g == 1544);
            if (e) cnt++;
            step(0, 1, 1, src[sp] ^ e, 0, 1, e, 0, cnt);
            sp++;
        end

        // clr_cnt with an error gives 1, clr alone gives 0.
        for (int g = 1700; g < 1800; g++) begin
            e = (g == 1710) || (g == 1760);
            b = (g == 1710) || (g == 1750);
            if (g == 1710) cnt = 1;
            if (g == 1750) cnt = 0;
            if (g == 1760) cnt = 1;
            step(0, 1, 1, src[sp] ^ e, b, 1, e, 0, cnt);
            sp++;
        end

        // Reset while locked, then relock after 28 valid bits.
        cnt = 0;
        step(1, 1, 1, src[sp], 0, 0, 0, 0, 0);
        for (int r = 0; r < 100; r++) begin
            step(0, 1, 1, src[sp], 0, r >= 27, 0, 0, 0);
            sp++;
        end

        // en=0 bits must not fill history: lock only 28 enabled bits later.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 40; r++) begin
            step(0, 0, 1, src[sp], 0, 0, 0, 0, 0);
            sp++;
        end
        for (int r = 0; r < 60; r++) begin
            step(0, 1, 1, src[sp], 0, r >= 27, 0, 0, 0);
            sp++;
        end

        // All-zero input must never lock.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 300; r++)
            step(0, 1, 1, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        load_in = 1'b0; en = 1'b0; clr_cnt = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the 12-bit PRBS data source used by the modulator chains (2FSK/2PSK/2DPSK/QPSK).
- Sits after the demodulator/decoder bit output.
- Self-synchronises to the incoming PRBS, then counts bit errors against a locally predicted flywheel sequence.
- Reports lock state and error count for BER measurement.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions required in SEARCH before lock.
- LOSS_WIN, 64: length of the loss-of-sync observation window, in valid bits.
- LOSS_ERR, 4: number of errors within one window that forces loss of sync.
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global enable; also gates the valid strobe.
- data_in  in  1  received bit (source data output).
- load_in  in  1  received-bit valid (source load output).
- clr_cnt  in  1  synchronous clear of err_cnt.
- lock  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse per counted bit error.
- err_cnt  out  CNT_W  saturating error count.
- sync_loss  out  1  one-cycle pulse on LOCKED->SEARCH.

Behaviour:
- Interface:
  - One clock, clk; all flops on its rising edge.
  - Reset rst is synchronous and active-high.
  - Reset value of every output is 0.
  - Reset mid-operation returns to SEARCH with history, fill, good, window and error counters all cleared.
- Valid bit: v = en & load_in. All state advances only on v; otherwise everything holds and pulses stay 0.
- History h[11:0]: h[0] is the newest bit.
  - Shift: h <= {h[10:0], b}.
  - Prediction: p = h[0]^h[3]^h[5]^h[11]. This matches the source recurrence r(n) = r(n-1)^r(n-4)^r(n-6)^r(n-12).
- State SEARCH:
  - First 12 valid bits only fill h; fill counter counts 0..12 and saturates.
  - After fill, on each valid bit: if data_in==p and h!=0, good++; otherwise good = 0.
  - Always shift b = data_in.
  - When good reaches LOCK_CNT, go to LOCKED on that same edge, with lock=1, and window/window-error counters cleared.
  - The h!=0 guard is required: all-zero input must never lock.
- State LOCKED (flywheel):
  - Shift b = p, not data_in, so a single channel error is counted exactly once.
  - On mismatch data_in!=p: err=1 for one cycle, err_cnt+1 (saturates at all-ones), window-error count+1.
  - Window counter counts valid bits 0..LOSS_WIN-1. At wrap, window-error count resets to 0.
  - If window-error count reaches LOSS_ERR: sync_loss=1 pulse, lock=0, go to SEARCH, clear fill and good. The error that triggers it is still counted.
  - err_cnt persists across SEARCH; only rst or clr_cnt clears it.
- Latency: lock, err and sync_loss are registered and change on the clock edge that samples the valid bit.
- clr_cnt:
  - Sets err_cnt to 0.
  - Same cycle as a counted error: err_cnt = 1.
  - Does not affect state, lock or the window.
- load_in held 0: checker frozen, no timeout.

Optional Feature:
- Macro PRBS_CHK_BITCNT_EN.
- Defined:
  - Adds output bit_cnt, width CNT_W+8, reset 0.
  - Counts valid bits while lock=1; saturates at all-ones.
  - Cleared by clr_cnt; clr_cnt coinciding with a counted bit gives 1.
  - Allows BER = err_cnt/bit_cnt.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then clean sequence from source seed all-ones (12 ones, then 0, ...), load_in=1 every cycle -> lock rises on edge sampling the 28th valid bit; err_cnt stays 0 over 1000 bits; no err pulses.
- Locked, invert bit 200 only -> exactly one err pulse on that bit's edge; err_cnt=1; lock stays 1.
- Locked, invert 4 bits within one 64-bit window -> 4 err pulses; sync_loss pulse on 4th error; err_cnt=4; lock=0. Clean bits continue -> lock again 28 valid bits later.
- 3 errors in one window, then 3 errors in the next window -> err_cnt=6; no sync_loss; lock stays 1.
- 300 valid zero bits after reset -> lock never asserts; err_cnt=0. Same stimulus with en=0 -> no state change.
- err_cnt=5 and clr_cnt coincides with an error -> err_cnt=1. rst asserted mid-lock -> next cycle lock=0, err_cnt=0, relock after 28 bits. Repeat with PRBS_CHK_BITCNT_EN: bit_cnt matches valid bits counted while locked.
